// File: rtl/i2c_req_arbiter.sv
// Two-client arbiter that serialises byte read/write requests onto one I2C byte engine.
// Each transaction is followed by an idle guard window so that EEPROM write cycles can finish.
module i2c_req_arbiter #(
  parameter int unsigned GAP_CNT_MAX = 200_000,
  parameter int unsigned TIMEOUT_MAX = 500_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  // client 0
  input  logic        req0,
  input  logic        wr0,
  input  logic [15:0] addr0,
  input  logic [7:0]  wdata0,
  output logic        ack0,
  output logic        done0,
  output logic [7:0]  rdata0,
  // client 1
  input  logic        req1,
  input  logic        wr1,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata1,
  output logic        ack1,
  output logic        done1,
  output logic [7:0]  rdata1,
  // status
  output logic        err,
  output logic        busy,
  // byte engine
  output logic        i2c_start,
  output logic        wr_en,
  output logic        rd_en,
  output logic [15:0] byte_addr,
  output logic [7:0]  wr_data,
  input  logic        i2c_end,
  input  logic [7:0]  rd_data
);

  localparam int unsigned GAP_W = $clog2(GAP_CNT_MAX + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_MAX + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CNT_MAX - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_MAX - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_END,
    ST_GAP
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  logic        ack0_d, ack1_d, done0_d, done1_d, err_d, busy_d;
  logic        i2c_start_d, wr_en_d, rd_en_d;
  logic [15:0] byte_addr_d;
  logic [7:0]  wr_data_d, rdata0_d, rdata1_d;

  // Arbitration: on contention the client not granted last wins; a lone requester always wins.
  logic winner;
  logic win_wr;

  always_comb begin
    winner = (req0 && req1) ? ~last_grant_q : req1;
    win_wr = winner ? wr1 : wr0;
  end

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    gap_cnt_d    = gap_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    err_d        = 1'b0;
    i2c_start_d  = 1'b0;
    wr_en_d      = wr_en;
    rd_en_d      = rd_en;
    byte_addr_d  = byte_addr;
    wr_data_d    = wr_data;
    rdata0_d     = rdata0;
    rdata1_d     = rdata1;

    unique case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          state_d      = ST_START;
          last_grant_d = winner;
          owner_d      = winner;
          ack0_d       = ~winner;
          ack1_d       = winner;
          byte_addr_d  = winner ? addr1 : addr0;
          wr_data_d    = winner ? wdata1 : wdata0;
          wr_en_d      = win_wr;
          rd_en_d      = ~win_wr;
        end
      end

      ST_START: begin
        state_d     = ST_WAIT_END;
        i2c_start_d = 1'b1;
        tmo_cnt_d   = '0;
      end

      ST_WAIT_END: begin
        // A real end pulse beats a timeout that expires on the same cycle.
        if (i2c_end) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
          done0_d   = ~owner_q;
          done1_d   = owner_q;
          wr_en_d   = 1'b0;
          rd_en_d   = 1'b0;
          if (rd_en) begin
            if (owner_q) rdata1_d = rd_data;
            else         rdata0_d = rd_data;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
          done0_d   = ~owner_q;
          done1_d   = owner_q;
          err_d     = 1'b1;
          wr_en_d   = 1'b0;
          rd_en_d   = 1'b0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      gap_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      err          <= 1'b0;
      busy         <= 1'b0;
      i2c_start    <= 1'b0;
      wr_en        <= 1'b0;
      rd_en        <= 1'b0;
      byte_addr    <= '0;
      wr_data      <= '0;
      rdata0       <= '0;
      rdata1       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      gap_cnt_q    <= gap_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      ack0         <= ack0_d;
      ack1         <= ack1_d;
      done0        <= done0_d;
      done1        <= done1_d;
      err          <= err_d;
      busy         <= busy_d;
      i2c_start    <= i2c_start_d;
      wr_en        <= wr_en_d;
      rd_en        <= rd_en_d;
      byte_addr    <= byte_addr_d;
      wr_data      <= wr_data_d;
      rdata0       <= rdata0_d;
      rdata1       <= rdata1_d;
    end
  end

endmodule

// File: doc/i2c_req_arbiter.md
I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 Parameter GAP_CNT_MAX, default 200_000; idle guard cycles after every transaction (4 ms at 50 MHz, EEPROM write cycle); legal range >= 1.
REQ-002 Parameter TIMEOUT_MAX, default 500_000; cycles allowed in WAIT_END before abort; legal range >= 2.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 sys_clk  in  1  system clock, 50 MHz.
REQ-005 sys_rst  in  1  asynchronous, active-high reset.
REQ-006 req0 / req1  in  1  client transaction request, held high until the matching ack.
REQ-007 wr0 / wr1  in  1  direction: 1 = byte write, 0 = byte read.
REQ-008 addr0 / addr1  in  16  EEPROM byte address.
REQ-009 wdata0 / wdata1  in  8  write data.
REQ-010 ack0 / ack1  out  1  1-cycle grant pulse; request fields are latched in the same cycle.
REQ-011 done0 / done1  out  1  1-cycle completion pulse.
REQ-012 rdata0 / rdata1  out  8  last read byte; holds its value until the next read for that client.
REQ-013 err  out  1  1-cycle pulse coincident with done on timeout.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 i2c_start  out  1  1-cycle start pulse to the I2C byte engine.
REQ-016 wr_en / rd_en  out  1  operation type to the engine; held from grant until completion.
REQ-017 byte_addr  out  16  latched address to the engine.
REQ-018 wr_data  out  8  latched write data to the engine.
REQ-019 i2c_end  in  1  1-cycle end-of-transaction pulse from the engine.
REQ-020 rd_data  in  8  engine read byte; valid while i2c_end is high.

Function
REQ-021 The block SHALL implement the FSM states IDLE, START, WAIT_END and GAP; all outputs SHALL be registered.
REQ-022 IDLE: when either req input is sampled high, the block SHALL select the winner, then at the same edge pulse ack for the winner, latch byte_addr, wr_data, wr_en = wr and rd_en = ~wr, and go to START.
REQ-023 Arbitration: when both requests are high, the client not granted last SHALL win; last_grant resets to 1, so client 0 wins first; a single requester always wins.
REQ-024 START: i2c_start SHALL be 1 for exactly one cycle, on the cycle after ack; the next state is WAIT_END and the timeout counter clears.
REQ-025 WAIT_END: when i2c_end is sampled high, at that edge the block SHALL pulse done for the owner, copy rd_data into the owner's rdata (reads only), clear wr_en and rd_en, and go to GAP.
REQ-026 Timeout: when the WAIT_END counter reaches TIMEOUT_MAX-1 without i2c_end, the block SHALL pulse done plus err, clear wr_en and rd_en, leave rdata unchanged, and go to GAP.
REQ-027 If i2c_end and timeout expiry occur in the same cycle, i2c_end SHALL take precedence: normal completion, err = 0.
REQ-028 GAP: the block SHALL stay in GAP for exactly GAP_CNT_MAX cycles, then go to IDLE; requests SHALL be ignored (no ack) during GAP.
REQ-029 i2c_end SHALL be ignored in IDLE, START and GAP.
REQ-030 The non-owner's ack, done and rdata SHALL never change during another client's transaction.
REQ-031 A req still high in IDLE after its done SHALL start a new transaction; clients must drop req after ack.
REQ-032 The gap counter SHALL be ceil(log2(GAP_CNT_MAX+1)) bits wide and the timeout counter ceil(log2(TIMEOUT_MAX+1)) bits wide; neither counter SHALL wrap.

Reset
REQ-033 Asserting sys_rst SHALL immediately force state IDLE, last_grant = 1, all counters 0 and all outputs 0, including rdata0/1, byte_addr and wr_data.
REQ-034 sys_rst asserted mid-transaction SHALL abort with no done or err pulse; the first grant after release SHALL occur no earlier than the first edge after deassertion.

Verification (bench: GAP_CNT_MAX = 10, TIMEOUT_MAX = 50)
REQ-035 Read: req0 = 1, wr0 = 0, addr0 = 16'h0005; engine returns i2c_end with rd_data = 8'hA5 twenty cycles after i2c_start -> ack0 at T, i2c_start at T+1, rd_en = 1 from T through completion, done0 with rdata0 = 8'hA5, busy low exactly 10 cycles after done0.
REQ-036 Write: req1 = 1, wr1 = 1, addr1 = 16'h0010, wdata1 = 8'h3C -> byte_addr = 16'h0010, wr_data = 8'h3C, wr_en = 1, done1 pulses and rdata1 stays 8'h00.
REQ-037 Contention: req0 and req1 raised in the same cycle after reset, each re-asserted after its done -> grant order 0, 1, 0, 1; no ack occurs during GAP.
REQ-038 Timeout: read granted and i2c_end never sent -> done and err pulse together 50 cycles after entering WAIT_END; rdata unchanged. Second case: i2c_end on the expiry cycle -> err = 0.
REQ-039 Reset mid-WAIT_END: all outputs go to 0 immediately, no done or err pulse; a later req0 is granted normally with client 0 priority.
REQ-040 Spurious i2c_end in IDLE and in GAP -> no done, no state change.
